// File: rtl/sim_mem_pkg.sv
// Shared definitions for the simulated read-memory responder.
// Holds default parameter values, the counter width and the response FSM state type.
package sim_mem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DEPTH  = 1024;
    localparam int unsigned DEF_OUTST  = 4;
    localparam int unsigned DEF_LAT_W  = 4;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/sim_req_fifo.sv
// In-order request FIFO holding accepted read word indices.
// Ports: clk, rst (async active-high), push_i/din_i write side, pop_i read side,
//        head_o (oldest entry), next_o (entry behind the head), full_o, empty_o, count_o.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sim_req_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         next_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_o = mem_q[rd_ptr_q];
    assign next_o = mem_q[rd_ptr_q + PTR_W'(1)];

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/sim_rd_mem_rsp.sv
// Simulated read memory with configurable response latency and error injection.
// Ports: clk, rst (async active-high); ar/ar_valid/ar_ready request channel;
//        r_valid/r_ready/r_data/r_err response channel; cfg_lat extra latency,
//        cfg_err_inj forced error flag; wr_en/wr_addr/wr_data backdoor preload;
//        req_cnt/rsp_cnt handshake counters.
module sim_rd_mem_rsp
    import sim_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned OUTST  = DEF_OUTST,
    parameter int unsigned LAT_W  = DEF_LAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ar,
    input  logic              ar_valid,
    output logic              ar_ready,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic              r_err,
    input  logic [LAT_W-1:0]  cfg_lat,
    input  logic              cfg_err_inj,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  req_cnt,
    output logic [CNT_W-1:0]  rsp_cnt
);

    localparam int unsigned OCC_W = $clog2(OUTST) + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];

    rsp_state_e        state_q;
    logic [LAT_W-1:0]  lat_q;
    logic              ar_ready_q;
    logic              r_valid_q;
    logic [DATA_W-1:0] r_data_q;
    logic              r_err_q;
    logic [CNT_W-1:0]  req_cnt_q;
    logic [CNT_W-1:0]  rsp_cnt_q;

    logic [ADDR_W-1:0] fifo_head;
    logic [ADDR_W-1:0] fifo_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_count;

    logic              ar_hs;
    logic              r_hs;
    logic              head_avail_c;
    logic              enter_wait_c;
    logic              enter_resp_c;
    logic [ADDR_W-1:0] src_addr_c;
    logic              oob_c;
    logic [DATA_W-1:0] rd_word_c;
    logic [OCC_W-1:0]  occ_d;

    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;
    assign r_err    = r_err_q;
    assign req_cnt  = req_cnt_q;
    assign rsp_cnt  = rsp_cnt_q;

    assign ar_hs = ar_valid & ar_ready_q & ~fifo_full;
    assign r_hs  = r_valid_q & r_ready;

    sim_req_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (OUTST)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ar_hs),
        .din_i   (ar),
        .pop_i   (r_hs),
        .head_o  (fifo_head),
        .next_o  (fifo_next),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Backdoor preload; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
            mem_r[IDX_W'(wr_addr)] <= wr_data;
        end
    end

    // Decide whether a new beat starts this cycle. Leaving RESP looks at the
    // entry behind the head because the head is being popped at this edge; an
    // entry pushed in the same cycle is left for IDLE so latency counts from its accept edge.
    always_comb begin
        head_avail_c = 1'b0;
        src_addr_c   = fifo_head;
        case (state_q)
            IDLE: head_avail_c = ~fifo_empty;
            RESP: begin
                head_avail_c = r_hs & (fifo_count > OCC_W'(1));
                src_addr_c   = fifo_next;
            end
            default: ;
        endcase
        enter_wait_c = head_avail_c & (cfg_lat != '0);
        enter_resp_c = (head_avail_c & (cfg_lat == '0)) |
                       ((state_q == WAIT) & (lat_q == LAT_W'(1)));
    end

    // Memory read for the beat being launched; the write port updates at the
    // same edge, so a colliding write is not visible here (read-before-write).
    assign oob_c     = (32'(src_addr_c) >= 32'(DEPTH));
    assign rd_word_c = mem_r[IDX_W'(src_addr_c)];

    // Response FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_err_q   <= 1'b0;
        end else if (enter_resp_c) begin
            state_q   <= RESP;
            r_valid_q <= 1'b1;
            r_data_q  <= oob_c ? '0 : rd_word_c;
            r_err_q   <= oob_c | cfg_err_inj;
        end else if (enter_wait_c) begin
            state_q   <= WAIT;
            lat_q     <= cfg_lat;
            r_valid_q <= 1'b0;
        end else if (state_q == WAIT) begin
            lat_q <= lat_q - LAT_W'(1);
        end else if (r_hs) begin
            state_q   <= IDLE;
            r_valid_q <= 1'b0;
        end
    end

    // Ready mirrors next-cycle occupancy so a full FIFO never accepts, even while popping.
    assign occ_d = fifo_count + OCC_W'(ar_hs) - OCC_W'(r_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_ready_q <= 1'b0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            ar_ready_q <= (occ_d < OCC_W'(OUTST));
            req_cnt_q  <= req_cnt_q + CNT_W'(ar_hs);
            rsp_cnt_q  <= rsp_cnt_q + CNT_W'(r_hs);
        end
    end

endmodule

// File: tb/tb_sim_rd_mem_rsp.sv
// Directed self-checking bench for sim_rd_mem_rsp (DEPTH reduced to 512 so
// out-of-range indices are reachable with the 10-bit address).
module tb_sim_rd_mem_rsp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 512;
    localparam int OUTST  = 4;
    localparam int LAT_W  = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] ar;
    logic              ar_valid;
    logic              ar_ready;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_err;
    logic [LAT_W-1:0]  cfg_lat;
    logic              cfg_err_inj;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [31:0]       req_cnt;
    logic [31:0]       rsp_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];
    int          cyc;
    int          acc;
    int          n;
    int          nxt;
    int          stale;
    int          rc [6];
    logic        av;
    logic        rv;
    logic [31:0] rd;

    sim_rd_mem_rsp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .OUTST  (OUTST),
        .LAT_W  (LAT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ar          (ar),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_err       (r_err),
        .cfg_lat     (cfg_lat),
        .cfg_err_inj (cfg_err_inj),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .req_cnt     (req_cnt),
        .rsp_cnt     (rsp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    // Present one request; returns at the negedge after its accept edge.
    task automatic send(input int a);
        ar       = ADDR_W'(a);
        ar_valid = 1'b1;
        for (int i = 0; i < 20 && !ar_ready; i++) @(negedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    // Cycles (negedges) until r_valid is seen, bounded.
    task automatic wait_rsp(output int c);
        c = 0;
        while (!r_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic single(input string tag, input int a, input int lat,
                          input logic [31:0] exp_d, input logic exp_e);
        int c;
        send(a);
        wait_rsp(c);
        check_eq({tag, "_lat"}, 64'(c), 64'(1 + lat));
        check_eq({tag, "_data"}, 64'(r_data), 64'(exp_d));
        check_eq({tag, "_err"}, 64'(r_err), 64'(exp_e));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ar = '0; ar_valid = 1'b0; r_ready = 1'b0; cfg_lat = '0;
        cfg_err_inj = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_ar_ready", 64'(ar_ready), 64'd0);
        check_eq("rst_r_valid", 64'(r_valid), 64'd0);
        check_eq("rst_r_data", 64'(r_data), 64'd0);
        check_eq("rst_r_err", 64'(r_err), 64'd0);
        check_eq("rst_req_cnt", 64'(req_cnt), 64'd0);
        check_eq("rst_rsp_cnt", 64'(rsp_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(ar_ready), 64'd1);

        preload(5, 32'hDEAD_BEEF);
        preload(0, 32'h1234_5678);
        for (int i = 10; i < 16; i++) preload(i, 32'hA000_0000 | 32'(i));
        preload(20, 32'h2020_2020);
        preload(88, 32'h0880_0880);
        preload(600, 32'hBAD0_0BAD);

        // Single read, zero latency
        r_ready = 1'b1;
        cfg_lat = '0;
        single("rd5", 5, 0, 32'hDEAD_BEEF, 1'b0);
        check_eq("rd5_req_cnt", 64'(req_cnt), 64'd1);
        check_eq("rd5_rsp_cnt", 64'(rsp_cnt), 64'd1);

        // Minimum nonzero latency
        cfg_lat = 4'd1;
        single("lat1", 11, 1, 32'hA000_000B, 1'b0);

        // Latency 3 with a mid-wait change to 9
        cfg_lat = 4'd3;
        send(12);
        @(negedge clk);
        cfg_lat = 4'd9;
        wait_rsp(cyc);
        check_eq("lat3_cyc", 64'(cyc + 1), 64'd4);
        check_eq("lat3_data", 64'(r_data), 64'hA000_000C);
        @(negedge clk);
        cfg_lat = '0;

        // Error responses
        single("oob", DEPTH, 0, 32'h0, 1'b1);
        cfg_err_inj = 1'b1;
        single("inj", 0, 0, 32'h1234_5678, 1'b1);
        cfg_err_inj = 1'b0;

        // Preload to an out-of-range index must not alias into the array
        single("wr_oob", 88, 0, 32'h0880_0880, 1'b0);

        // Read-before-write on the RESP entry edge
        send(20);
        wr_en = 1'b1; wr_addr = ADDR_W'(20); wr_data = 32'h5555_AAAA;
        wait_rsp(cyc);
        wr_en = 1'b0;
        check_eq("rbw_cyc", 64'(cyc), 64'd1);
        check_eq("rbw_old", 64'(r_data), 64'h2020_2020);
        @(negedge clk);
        single("rbw_new", 20, 0, 32'h5555_AAAA, 1'b0);

        // Backpressure: fresh counters, 6 requests against a 4-deep FIFO
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r_ready  = 1'b0;
        acc      = 0;
        ar       = ADDR_W'(10);
        ar_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            av = ar_ready;
            @(negedge clk);
            if (av) begin
                acc++;
                ar = ADDR_W'(10 + acc);
            end
        end
        ar_valid = 1'b0;
        check_eq("bp_accepted", 64'(acc), 64'd4);
        check_eq("bp_ready_low", 64'(ar_ready), 64'd0);
        check_eq("bp_req_cnt", 64'(req_cnt), 64'd4);
        check_eq("bp_r_valid", 64'(r_valid), 64'd1);
        check_eq("bp_head", 64'(r_data), 64'hA000_000A);
        @(negedge clk);
        check_eq("bp_hold_valid", 64'(r_valid), 64'd1);
        check_eq("bp_hold_data", 64'(r_data), 64'hA000_000A);

        ar       = ADDR_W'(14);
        ar_valid = 1'b1;
        nxt      = 14;
        r_ready  = 1'b1;
        n        = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            av = ar_valid & ar_ready;
            rv = r_valid;
            rd = r_data;
            if (rv) begin
                check_eq($sformatf("bp_order%0d", n), 64'(rd), 64'(32'hA000_000A + 32'(n)));
                rc[n] = c;
                n++;
            end
            @(negedge clk);
            if (av) begin
                nxt++;
                if (nxt > 15) ar_valid = 1'b0;
                else ar = ADDR_W'(nxt);
            end
        end
        check_eq("bp_rsp_total", 64'(n), 64'd6);
        check_eq("bp_first4_b2b", 64'(rc[3] - rc[0]), 64'd3);
        check_eq("bp_req_cnt6", 64'(req_cnt), 64'd6);
        check_eq("bp_rsp_cnt6", 64'(rsp_cnt), 64'd6);
        check_eq("bp_idle", 64'(r_valid), 64'd0);

        // Reset with requests pending
        r_ready = 1'b0;
        send(10);
        send(11);
        send(12);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_r_valid", 64'(r_valid), 64'd0);
        check_eq("mid_rst_ready", 64'(ar_ready), 64'd0);
        check_eq("mid_rst_req_cnt", 64'(req_cnt), 64'd0);
        check_eq("mid_rst_rsp_cnt", 64'(rsp_cnt), 64'd0);
        rst     = 1'b0;
        r_ready = 1'b1;
        stale   = 0;
        repeat (6) begin
            @(negedge clk);
            if (r_valid) stale++;
        end
        check_eq("mid_rst_stale", 64'(stale), 64'd0);
        single("post_mid_rst", 5, 0, 32'hDEAD_BEEF, 1'b0);
        check_eq("post_mid_rsp_cnt", 64'(rsp_cnt), 64'd1);

        // Request counter wrap
        dut.req_cnt_q = 32'hFFFF_FFFF;
        send(13);
        check_eq("req_cnt_wrap", 64'(req_cnt), 64'd0);
        wait_rsp(cyc);
        check_eq("wrap_rsp_data", 64'(r_data), 64'hA000_000D);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_rd_mem_rsp.md
SIM_RD_MEM_RSP -- requirements
Module: sim_rd_mem_rsp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: read data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10: word-index address width.
REQ-003 SHALL have parameter DEPTH, default 1024: number of words, with DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter OUTST, default 4: number of outstanding read requests, a power of 2 and at least 2.
REQ-005 SHALL have parameter LAT_W, default 4: width of the latency configuration.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ar  in  ADDR_W  read word index.
- ar_valid  in  1  request valid.
- ar_ready  out  1  request accepted when high together with ar_valid.
- r_valid  out  1  response valid.
- r_ready  in  1  response consumed when high together with r_valid.
- r_data  out  DATA_W  read data.
- r_err  out  1  response is an error response.
- cfg_lat  in  LAT_W  extra response latency in cycles.
- cfg_err_inj  in  1  force the error flag on responses.
- wr_en  in  1  backdoor preload write enable.
- wr_addr  in  ADDR_W  preload write index.
- wr_data  in  DATA_W  preload write data.
- req_cnt  out  32  accepted-request counter.
- rsp_cnt  out  32  completed-response counter.

Function
REQ-007 SHALL store accepted ar values in an in-order request FIFO of OUTST entries.
REQ-008 SHALL drive ar_ready = (FIFO occupancy < OUTST), with no bypass when full, even if the FIFO pops in the same cycle.
REQ-009 SHALL run a response FSM with states IDLE, WAIT and RESP.
- IDLE: FIFO empty, r_valid=0.
- IDLE -> WAIT: FIFO non-empty and cfg_lat != 0; load the latency counter with cfg_lat.
- IDLE -> RESP: FIFO non-empty and cfg_lat == 0.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
- RESP: hold r_valid=1, r_data and r_err stable until r_ready.
REQ-010 On an r_valid&r_ready handshake, SHALL pop the FIFO head and take the next state from the post-pop head per REQ-009 IDLE rules.
- This gives back-to-back RESP beats at one per cycle when cfg_lat=0.
REQ-011 Latency SHALL be measured from the accept edge: a request accepted at edge k into an empty, idle block SHALL show r_valid in cycle k+1+cfg_lat.
REQ-012 SHALL sample cfg_lat only when leaving IDLE or RESP; a change during WAIT SHALL have no effect on the current beat.
REQ-013 SHALL register r_data from memory[head] on entry to RESP.
- Addresses >= DEPTH: r_data=0 and r_err=1.
- Otherwise r_err = the value of cfg_err_inj sampled at the same edge.
REQ-014 On a wr_en write to the same index in the cycle of the RESP entry, SHALL return the old data (read-before-write).
- wr_en with wr_addr >= DEPTH SHALL be ignored.
REQ-015 req_cnt SHALL increment on each ar handshake and rsp_cnt on each r handshake, both wrapping modulo 2**32.
REQ-016 A simultaneous push and pop SHALL leave occupancy unchanged; the FIFO pointers SHALL wrap modulo OUTST.
REQ-017 Memory contents SHALL be held in the mem_r array with no reset value; the bench preloads via the wr port or hierarchically.

Reset
REQ-018 While rst=1, regardless of the operation in progress, the block SHALL hold:
- FSM in IDLE, FIFO empty.
- ar_ready=0, r_valid=0, r_data=0, r_err=0.
- req_cnt=0, rsp_cnt=0.
REQ-019 ar_ready SHALL be 1 in the first cycle after rst falls.
- Requests in flight at reset assertion SHALL be dropped with no response.

Structure
REQ-020 Package sim_mem_pkg SHALL hold:
- the state enum (IDLE, WAIT, RESP);
- default parameter constants;
- the counter width constant (32).
REQ-021 The request FIFO SHALL be a sub-module, sim_req_fifo, parametrised by width and depth, with full, empty and count outputs.

Verification
REQ-022 Single read: preload mem[5]=0xDEADBEEF, cfg_lat=0, r_ready=1, ar=5 for one cycle -> r_valid in the next cycle, r_data=0xDEADBEEF, r_err=0.
REQ-023 Latency: cfg_lat=3, one request -> r_valid exactly 4 cycles after the accept edge; cfg_lat changed to 9 during WAIT -> timing unchanged.
REQ-024 Backpressure/full: OUTST=4, r_ready=0, 6 requests offered back-to-back -> 4 accepted, then ar_ready=0; r_ready=1 -> 4 in-order responses on consecutive cycles, then the remaining 2; req_cnt=rsp_cnt=6.
REQ-025 Error: ar=DEPTH -> r_err=1, r_data=0; cfg_err_inj=1 with ar=0 -> r_err=1, data valid.
REQ-026 Reset mid-op: 3 pending requests, rst pulsed -> r_valid=0, counters 0, no stale response after release; a new request completes normally.
REQ-027 Counter wrap: req_cnt forced to 0xFFFFFFFF, one handshake -> req_cnt=0.
